// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op codes, FSM state encoding and default cycle counts.
// Combinational helpers only; no latency, no flow control.
package mdu_pkg;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_MADD  = 3'd7;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_t;

  function automatic logic is_mul_op(input logic [2:0] op, input logic madd_en);
    return (op == OP_MULT) || (op == OP_MULTU) || (madd_en && (op == OP_MADD));
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: products, quotient/remainder, MADD accumulate (MDU_MADD_EN).
// Zero latency; no flow control, results are sampled by mdu_hilo on start.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [31:0] o_res_hi,
  output logic [31:0] o_res_lo,
  output logic        o_div_zero
);

  logic signed [63:0] w_sprod;
  logic [63:0]        w_uprod;
  logic [31:0]        w_div_u;
  logic [31:0]        w_uq;
  logic [31:0]        w_ur;
  logic [31:0]        w_abs_rs;
  logic [31:0]        w_abs_rt;
  logic [31:0]        w_div_s;
  logic [31:0]        w_mq;
  logic [31:0]        w_mr;
  logic [31:0]        w_sq;
  logic [31:0]        w_sr;

  assign w_sprod = $signed({{32{i_rs[31]}}, i_rs}) * $signed({{32{i_rt[31]}}, i_rt});
  assign w_uprod = {32'd0, i_rs} * {32'd0, i_rt};

  // Divisor forced to 1 on zero so the dividers never see x/0; the result is discarded anyway.
  assign o_div_zero = (i_rt == 32'd0);
  assign w_div_u    = o_div_zero ? 32'd1 : i_rt;
  assign w_uq       = i_rs / w_div_u;
  assign w_ur       = i_rs % w_div_u;

  // Signed divide on magnitudes: 0x80000000 / -1 yields quotient 0x80000000, remainder 0.
  assign w_abs_rs = i_rs[31] ? -i_rs : i_rs;
  assign w_abs_rt = i_rt[31] ? -i_rt : i_rt;
  assign w_div_s  = o_div_zero ? 32'd1 : w_abs_rt;
  assign w_mq     = w_abs_rs / w_div_s;
  assign w_mr     = w_abs_rs % w_div_s;
  assign w_sq     = (i_rs[31] ^ i_rt[31]) ? -w_mq : w_mq;
  assign w_sr     = i_rs[31] ? -w_mr : w_mr;

`ifdef MDU_MADD_EN
  logic [63:0] w_acc;
  assign w_acc = {i_hi, i_lo} + $unsigned(w_sprod);
`else
  logic w_unused;
  assign w_unused = ^{i_hi, i_lo};
`endif

  always_comb begin
    o_res_hi = 32'd0;
    o_res_lo = 32'd0;
    case (i_op)
      OP_MULT:  {o_res_hi, o_res_lo} = $unsigned(w_sprod);
      OP_MULTU: {o_res_hi, o_res_lo} = w_uprod;
      OP_DIV:   begin o_res_hi = w_sr; o_res_lo = w_sq; end
      OP_DIVU:  begin o_res_hi = w_ur; o_res_lo = w_uq; end
`ifdef MDU_MADD_EN
      OP_MADD:  {o_res_hi, o_res_lo} = w_acc;
`endif
      default:  begin o_res_hi = 32'd0; o_res_lo = 32'd0; end
    endcase
  end

endmodule

// File: rtl/mdu_hilo.sv
// Multiply/divide unit with HI/LO registers; fixed MULT_CYCLES/DIV_CYCLES busy, commit at last busy edge.
// No backpressure: md_en while busy is ignored (hazard unit stalls); MADD built only with MDU_MADD_EN.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_en,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
`ifdef MDU_MADD_EN
  localparam logic MADD_EN = 1'b1;
`else
  localparam logic MADD_EN = 1'b0;
`endif

  mdu_state_t       r_state;
  mdu_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [31:0]      r_res_hi;
  logic [31:0]      r_res_lo;
  logic             r_div_zero;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic             w_idle;
  logic             w_start_mul;
  logic             w_start_div;
  logic             w_mthi;
  logic             w_mtlo;
  logic             w_busy;
  logic             w_commit;
  logic [31:0]      w_res_hi;
  logic [31:0]      w_res_lo;
  logic             w_div_zero;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_start_mul = md_en & w_idle & is_mul_op(md_op, MADD_EN);
  assign w_start_div = md_en & w_idle & is_div_op(md_op);
  assign w_mthi      = md_en & w_idle & (md_op == OP_MTHI);
  assign w_mtlo      = md_en & w_idle & (md_op == OP_MTLO);

  mdu_arith u_arith (
    .i_op       (md_op),
    .i_rs       (rs_val),
    .i_rt       (rt_val),
    .i_hi       (r_hi),
    .i_lo       (r_lo),
    .o_res_hi   (w_res_hi),
    .o_res_lo   (w_res_lo),
    .o_div_zero (w_div_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_start_mul) begin
          w_state_nxt = ST_MUL;
          w_cnt_nxt   = CNT_W'(MULT_CYCLES - 1);
        end else if (w_start_div) begin
          w_state_nxt = ST_DIV;
          w_cnt_nxt   = CNT_W'(DIV_CYCLES - 1);
        end
      end
      ST_MUL, ST_DIV: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_busy   = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      ST_MUL, ST_DIV: begin
        w_busy   = 1'b1;
        w_commit = (r_cnt == '0);
      end
      default: begin
        w_busy   = 1'b0;
        w_commit = 1'b0;
      end
    endcase
  end

  // Pending result is captured at start; a zero-divisor divide commits nothing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_res_hi   <= 32'd0;
      r_res_lo   <= 32'd0;
      r_div_zero <= 1'b0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
    end else begin
      if (w_start_mul | w_start_div) begin
        r_res_hi   <= w_res_hi;
        r_res_lo   <= w_res_lo;
        r_div_zero <= w_start_div & w_div_zero;
      end
      if (w_commit && !r_div_zero) begin
        r_hi <= r_res_hi;
        r_lo <= r_res_lo;
      end
      if (w_mthi) r_hi <= rs_val;
      if (w_mtlo) r_lo <= rs_val;
    end
  end

  assign busy = w_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
